// File: rtl/mlp_mac_sequencer.sv
// Sequencer around a 4-lane int8 MAC chain: streams operand beats, closes the
// accumulation loop, then rounds, shifts, optionally ReLUs and saturates to int8.
module mlp_mac_sequencer #(
  parameter int WIDTH_SUM = 32,
  parameter int WIDTH_A   = 32,
  parameter int WIDTH_B   = 32,
  parameter int LEN_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_relu,
  input  logic [WIDTH_SUM-1:0] bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_A-1:0]   in_a,
  input  logic [WIDTH_B-1:0]   in_b,
  output logic [WIDTH_SUM-1:0] mac_sum0,
  output logic [WIDTH_A-1:0]   mac_a,
  output logic [WIDTH_B-1:0]   mac_b,
  input  logic [WIDTH_SUM-1:0] mac_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [7:0]           res_data,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_POST, S_OUT} state_t;

  localparam logic [LEN_W-1:0]         CNT_ONE = 1;
  localparam logic signed [WIDTH_SUM:0] ONE_EXT = 1;
  localparam logic signed [WIDTH_SUM:0] SAT_MAX = 127;
  localparam logic signed [WIDTH_SUM:0] SAT_MIN = -128;

  state_t                      r_state;
  logic signed [WIDTH_SUM-1:0] r_acc;
  logic [LEN_W-1:0]            r_cnt;
  logic [4:0]                  r_shift;
  logic                        r_relu;
  logic                        r_in_ready;
  logic                        r_busy;
  logic                        r_res_valid;
  logic [7:0]                  r_res_data;

  logic signed [WIDTH_SUM:0]   w_acc_ext;
  logic signed [WIDTH_SUM:0]   w_rnd;
  logic signed [WIDTH_SUM:0]   w_t;
  logic signed [WIDTH_SUM:0]   w_shr;
  logic signed [WIDTH_SUM:0]   w_relu;
  logic [7:0]                  w_sat;

  assign mac_sum0  = r_acc;
  assign mac_a     = in_a;
  assign mac_b     = in_b;
  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

  // One extra bit keeps acc + rounding constant from overflowing before the shift.
  assign w_acc_ext = {r_acc[WIDTH_SUM-1], r_acc};
  assign w_rnd     = (r_shift == 5'd0) ? '0 : (ONE_EXT << (r_shift - 5'd1));
  assign w_t       = w_acc_ext + w_rnd;
  assign w_shr     = w_t >>> r_shift;
  assign w_relu    = (r_relu && w_shr[WIDTH_SUM]) ? '0 : w_shr;
  assign w_sat     = (w_relu > SAT_MAX) ? 8'h7F :
                     (w_relu < SAT_MIN) ? 8'h80 : w_relu[7:0];

  // NOTE: every register here is updated with <= so all next-state values are
  // computed from the same pre-edge snapshot, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: reset clears every control and datapath register; there is no
      // memory array here, so nothing is left uninitialised after reset.
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= bias;
            r_cnt   <= cfg_len;
            r_shift <= cfg_shift;
            r_relu  <= cfg_relu;
            r_busy  <= 1'b1;
            if (cfg_len != '0) begin
              r_state    <= S_ACC;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= S_POST;
            end
          end
        end
        S_ACC: begin
          if (in_valid && r_in_ready) begin
            r_acc <= mac_out;
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              r_state    <= S_POST;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_POST: begin
          r_res_data  <= w_sat;
          r_res_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_mac_sequencer.sv
// Bench for mlp_mac_sequencer: behavioural MAC chain, directed scenarios and
// randomized neurons checked against an arithmetic reference model.
module tb_mlp_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_len;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] mac_sum0;
  logic [31:0] mac_a;
  logic [31:0] mac_b;
  logic [31:0] mac_out;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mlp_mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_sum0(mac_sum0), .mac_a(mac_a), .mac_b(mac_b),
    .mac_out(mac_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  function automatic int dot4(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++)
      s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
    return s;
  endfunction

  // Behavioural MAC chain: combinational, zero latency.
  always_comb mac_out = mac_sum0 + 32'(dot4(mac_a, mac_b));

  // Reference post-processing: round half up, floor-shift, ReLU, clamp to int8.
  function automatic logic [7:0] ref_post(input logic [31:0] acc, input int shift, input bit relu);
    longint t = longint'($signed(acc));
    if (shift > 0) t += longint'(1) << (shift - 1);
    t = t >>> shift;
    if (relu && t < 0) t = 0;
    if (t > 127) t = 127;
    else if (t < -128) t = -128;
    return t[7:0];
  endfunction

  task automatic start_neuron(input logic [31:0] b, input int len, input int shift, input bit relu);
    bias      = b;
    cfg_len   = len[7:0];
    cfg_shift = shift[4:0];
    cfg_relu  = relu;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    bias      = $urandom;
    cfg_len   = 8'($urandom);
    cfg_shift = 5'($urandom);
    cfg_relu  = 1'($urandom);
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin
      in_a = $urandom;
      in_b = $urandom;
      @(negedge clk);
    end
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    cfg_len = '0; cfg_shift = '0; cfg_relu = 1'b0; bias = '0; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_neuron(32'd500, 3, 0, 0);
    send_beat($urandom, $urandom, 0);
    #2;
    start = 1'($urandom); in_valid = 1'($urandom); res_ready = 1'($urandom);
    in_a = $urandom; in_b = $urandom; bias = $urandom;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy, res_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got in_ready/busy/res_valid=%b want 000", {in_ready, busy, res_valid});
    end
    checks++;
    if (mac_sum0 !== 32'd0 || res_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_data got mac_sum0=%h res_data=%h want 0/0", mac_sum0, res_data);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle got in_ready=%b busy=%b want 0/0", in_ready, busy);
      end
    end
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    start_neuron(32'd10, 2, 0, 0);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_acc_state got in_ready=%b busy=%b want 1/1", in_ready, busy);
    end
    send_beat(32'h01010101, 32'h02020202, 0);
    checks++;
    if (mac_sum0 !== 32'd18) begin
      errors++;
      $display("FAIL basic_acc1 got %0d want 18", mac_sum0);
    end
    send_beat(32'h01010101, 32'h02020202, 0);
    checks++;
    if (mac_sum0 !== 32'd26 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_acc2 got acc=%0d res_valid=%b in_ready=%b want 26/0/0",
               mac_sum0, res_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h1A) begin
      errors++;
      $display("FAIL basic_result got valid=%b data=%h want 1/1a", res_valid, res_data);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake got valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_post_table();
    int         t_bias [7] = '{1000, -1000, -1000, 6, -6, 5, -3};
    int         t_shift[7] = '{2, 2, 2, 2, 2, 2, 0};
    bit         t_relu [7] = '{0, 0, 1, 0, 0, 0, 0};
    logic [7:0] t_exp  [7] = '{8'h7F, 8'h80, 8'h00, 8'h02, 8'hFF, 8'h01, 8'hFD};
    res_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      start_neuron(32'(t_bias[k]), 0, t_shift[k], t_relu[k]);
      checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL post_early[%0d] got valid=%b in_ready=%b busy=%b want 0/0/1",
                 k, res_valid, in_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== t_exp[k]) begin
        errors++;
        $display("FAIL post_result[%0d] got valid=%b data=%h want 1/%h", k, res_valid, res_data, t_exp[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_gaps();
    res_ready = 1'b0;
    start_neuron(32'd37, 3, 0, 0);
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b0;
      repeat (2) begin
        in_a = $urandom; in_b = $urandom;
        @(negedge clk);
        checks++;
        if (mac_sum0 !== 32'd37 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL gap_hold[%0d] got acc=%0d in_ready=%b want 37/1", n, mac_sum0, in_ready);
        end
      end
      send_beat(32'hFF01FF01, 32'h01010101, 0);
    end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      start = 1'($urandom); cfg_len = 8'($urandom); bias = $urandom;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 8'h25 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure[%0d] got valid=%b data=%h busy=%b want 1/25/1",
                 k, res_valid, res_data, busy);
      end
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release got valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_abort();
    res_ready = 1'b1;
    start_neuron($urandom, 3, 0, 0);
    send_beat($urandom, $urandom, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_acc got in_ready=%b busy=%b want 0/0", in_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    start_neuron(32'd1, 1, 0, 0);
    send_beat(32'h00000003, 32'h00000004, 0);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'h0D) begin
      errors++;
      $display("FAIL abort_fresh got valid=%b data=%h want 1/0d", res_valid, res_data);
    end
    @(negedge clk);
    res_ready = 1'b0;
    start_neuron(32'd100, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_out got valid=%b busy=%b want 0/0", res_valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] b   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
      int          len = $urandom_range(0, 8);
      int          sh  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 12);
      bit          rl  = 1'($urandom);
      int          hold = $urandom_range(0, 3);
      logic [31:0] acc = b;
      logic [7:0]  exp_res;
      res_ready = (hold == 0);
      start_neuron(b, len, sh, rl);
      for (int k = 0; k < len; k++) begin
        logic [31:0] a  = $urandom;
        logic [31:0] w  = $urandom;
        acc = acc + 32'(dot4(a, w));
        send_beat(a, w, $urandom_range(0, 2));
        checks++;
        if (mac_sum0 !== acc || in_ready !== (k != len - 1)) begin
          errors++;
          $display("FAIL rand_acc[%0d.%0d] got acc=%h in_ready=%b want %h/%b",
                   n, k, mac_sum0, in_ready, acc, (k != len - 1));
        end
      end
      exp_res = ref_post(acc, sh, rl);
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp_res) begin
        errors++;
        $display("FAIL rand_result[%0d] got valid=%b data=%h want 1/%h", n, res_valid, res_data, exp_res);
      end
      if (hold > 0) begin
        repeat (hold) @(negedge clk);
        res_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_done[%0d] got valid=%b busy=%b want 0/0", n, res_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_post_table();
    test_back_to_back_gaps();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
